regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (we3/wa3/wd3) between two writeback requesters:
//  A = ALU/execute results, B = memory-load results.
//  Each requester gets a small FIFO; a round-robin scheduler drains one entry per cycle into a
//  registered write port.
//  Also reports read-after-write hazards for the two decode read addresses, so decode can stall
//  while a write to that register is still queued.
// PARAMETERS
//  DATA_W     64  width of write data
//  ADDR_W     5   width of register address
//  ZERO_REG   31  address of hard-wired zero register; writes to it are discarded
//  FIFO_DEPTH 2   entries per requester FIFO (power of 2, >=2)
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  a_valid    in   1       requester A has a write
//  a_ready    out  1       A FIFO can accept (not full)
//  a_addr     in   ADDR_W  A destination register
//  a_data     in   DATA_W  A write data
//  b_valid    in   1       requester B has a write
//  b_ready    out  1       B FIFO can accept (not full)
//  b_addr     in   ADDR_W  B destination register
//  b_data     in   DATA_W  B write data
//  we3        out  1       register-file write enable (registered)
//  wa3        out  ADDR_W  register-file write address (registered)
//  wd3        out  DATA_W  register-file write data (registered)
//  chk_addr1  in   ADDR_W  decode read address 1
//  chk_addr2  in   ADDR_W  decode read address 2
//  raw_stall  out  1       a queued (not yet on port) write targets chk_addr1/2
//  busy       out  1       any FIFO non-empty or we3 high
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - both FIFOs empty; we3=0, wa3=0, wd3=0; rr pointer = A.
//   - Observed outputs: a_ready=b_ready=1, raw_stall=0, busy=0.
//   - Reset mid-operation discards all queued writes; nothing is written afterwards.
//  Accept:
//   - x_valid & x_ready at edge -> entry pushed.
//   - x_ready = (count_x != FIFO_DEPTH); it depends only on registered count, not on same-cycle
//     pop, so no combinational valid->ready path.
//   - Accepted entries with addr==ZERO_REG are dropped (not pushed, never raise we3).
//   - x_valid while !x_ready: no effect; requester must hold.
//  Schedule, every cycle:
//   - only A non-empty -> pop A; only B non-empty -> pop B.
//   - both non-empty -> pop the side named by rr; rr then flips to the other side.
//   - rr changes only on a contested grant.
//   - The popped head is registered into wa3/wd3 with we3=1 at the same edge.
//   - No pop -> we3=0; wa3/wd3 hold.
//  Latency:
//   - entry accepted at edge k (empty FIFO, no contention) -> we3=1 in cycle after edge k+1.
//   - regfile captures at edge k+2.
//   - Throughput 1 write/cycle total.
//  Ordering:
//   - FIFO order kept within a requester.
//   - No ordering between A and B; the producer guarantees A and B never have outstanding
//     writes to the same register.
//  Hazard:
//   - raw_stall = OR over valid FIFO entries (both sides) of (addr==chk_addr1 | addr==chk_addr2).
//   - The entry currently on wa3 is excluded: the regfile bypass covers it.
//   - chk_addr==ZERO_REG never stalls.
//   - Combinational from state and chk_addr only.
//  Full FIFO + pop same edge: no push that edge (ready was 0); ready rises next cycle.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// TESTING
//  1. Reset; A pushes (addr 3, 0xAA) -> we3=1, wa3=3, wd3=0xAA two edges later, busy drops after.
//  2. A and B push every cycle (A addr 1..4, B addr 5..8) -> port alternates A1,B5,A2,B6,...;
//     a_ready/b_ready deassert when count hits 2.
//  3. A pushes addr 31, data 0xFF -> accepted (a_ready=1); we3 never asserts; busy stays 0.
//  4. B queues addr 7 behind a full FIFO, chk_addr1=7 -> raw_stall=1 until entry reaches wa3,
//     then 0.
//  5. Fill both FIFOs, pull reset_n low mid-drain -> we3=0 immediately, ready=1; no further
//     writes after release.
//  6. A held full, B idle -> one pop/cycle, a_ready rises the cycle after first pop; no entry
//     lost or duplicated.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between requester A (execute) and B (load) through
// per-requester FIFOs, a round-robin drain and a read-after-write hazard check for decode.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned ZERO_REG   = 31,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_b_valid,
    output logic              o_b_ready,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_we3,
    output logic [ADDR_W-1:0] o_wa3,
    output logic [DATA_W-1:0] o_wd3,
    input  logic [ADDR_W-1:0] i_chk_addr1,
    input  logic [ADDR_W-1:0] i_chk_addr2,
    output logic              o_raw_stall,
    output logic              o_busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

    // Index 0 is requester A, index 1 is requester B.
    logic [ADDR_W-1:0] r_addr [2][FIFO_DEPTH];
    logic [DATA_W-1:0] r_data [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr [2];
    logic [PTR_W-1:0]  r_rptr [2];
    logic [CNT_W-1:0]  r_cnt  [2];
    logic              r_rr;
    logic              r_we3;
    logic [ADDR_W-1:0] r_wa3;
    logic [DATA_W-1:0] r_wd3;

    logic [1:0]        w_in_valid;
    logic [ADDR_W-1:0] w_in_addr [2];
    logic [DATA_W-1:0] w_in_data [2];
    logic [1:0]        w_ready;
    logic [1:0]        w_push;
    logic [1:0]        w_nempty;
    logic [1:0]        w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic              w_hit;

    always_comb begin
        w_in_valid   = {i_b_valid, i_a_valid};
        w_in_addr[0] = i_a_addr;
        w_in_addr[1] = i_b_addr;
        w_in_data[0] = i_a_data;
        w_in_data[1] = i_b_data;
        for (int s = 0; s < 2; s++) begin
            // Ready looks only at the registered count, never at this cycle's pop.
            w_ready[s]  = (r_cnt[s] != CNT_W'(FIFO_DEPTH));
            w_push[s]   = w_in_valid[s] & w_ready[s] & (w_in_addr[s] != ZeroAddr);
            w_nempty[s] = (r_cnt[s] != '0);
        end
        if (&w_nempty) begin
            w_pop = r_rr ? 2'b10 : 2'b01;
        end else begin
            w_pop = w_nempty;
        end
        if (w_pop[1]) begin
            w_head_addr = r_addr[1][r_rptr[1]];
            w_head_data = r_data[1][r_rptr[1]];
        end else begin
            w_head_addr = r_addr[0][r_rptr[0]];
            w_head_data = r_data[0][r_rptr[0]];
        end
    end

    always_ff @(posedge i_clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) begin
                r_addr[s][r_wptr[s]] <= w_in_addr[s];
                r_data[s][r_wptr[s]] <= w_in_data[s];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int s = 0; s < 2; s++) begin
                r_wptr[s] <= '0;
                r_rptr[s] <= '0;
                r_cnt[s]  <= '0;
            end
            r_rr  <= 1'b0;
            r_we3 <= 1'b0;
            r_wa3 <= '0;
            r_wd3 <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (w_push[s]) r_wptr[s] <= r_wptr[s] + PTR_W'(1);
                if (w_pop[s])  r_rptr[s] <= r_rptr[s] + PTR_W'(1);
                r_cnt[s] <= r_cnt[s] + CNT_W'(w_push[s]) - CNT_W'(w_pop[s]);
            end
            if (&w_nempty) r_rr <= ~r_rr;
            r_we3 <= |w_pop;
            if (|w_pop) begin
                r_wa3 <= w_head_addr;
                r_wd3 <= w_head_data;
            end
        end
    end

    // Popped entries have left the FIFO, so the one on wa3 is naturally excluded.
    always_comb begin
        w_hit = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                logic [PTR_W-1:0] w_off;
                w_off = PTR_W'(i) - r_rptr[s];
                if (({1'b0, w_off} < r_cnt[s]) &&
                    (((r_addr[s][i] == i_chk_addr1) && (i_chk_addr1 != ZeroAddr)) ||
                     ((r_addr[s][i] == i_chk_addr2) && (i_chk_addr2 != ZeroAddr)))) begin
                    w_hit = 1'b1;
                end
            end
        end
    end

    assign o_a_ready   = w_ready[0];
    assign o_b_ready   = w_ready[1];
    assign o_we3       = r_we3;
    assign o_wa3       = r_wa3;
    assign o_wd3       = r_wd3;
    assign o_raw_stall = w_hit;
    assign o_busy      = (|w_nempty) | r_we3;

endmodule
